// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter for a shared FIFO; accepted word reaches fifo_push/fifo_din one cycle later.
// Backpressure: req_ready drops for all requesters once the credit counter (occ) reaches DEPTH.
module fifo_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int BITS  = 32,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*BITS-1:0]        req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         fifo_push,
    output logic [BITS-1:0]              fifo_din,
    input  logic                         fifo_pop,
    input  logic                         fifo_pndng,
    input  logic                         fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         overflow_err
);

    localparam int OW = $clog2(DEPTH+1);
    localparam int GW = $clog2(N_REQ);
    localparam logic [GW-1:0]    LAST_RST = GW'(N_REQ-1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [GW-1:0]   last;
    logic [GW-1:0]   winner;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic            pop_eff;
    logic [BITS-1:0] win_data;
    int              idx;

    // Search starts one past the last grant and wraps, so nobody is starved.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    assign can_accept = (occ < OW'(DEPTH));
    assign req_ready  = (found && can_accept && !rst) ? (ONE << winner) : '0;
    assign accept     = |(req_valid & req_ready);
    assign pop_eff    = fifo_pop & fifo_pndng;
    assign win_data   = req_data[int'(winner)*BITS +: BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            last      <= LAST_RST;
            grant_id  <= '0;
        end else begin
            fifo_push <= accept;
            if (accept) begin
                fifo_din <= win_data;
                last     <= winner;
                grant_id <= winner;
            end
        end
    end

    // Credits are consumed at accept time, so the registered push can never overrun the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ + OW'(accept) - OW'(pop_eff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (fifo_push && fifo_full) begin
            overflow_err <= 1'b1;
        end
    end

endmodule
